// File: rtl/fb_pkg.sv
// Shared framebuffer types and defaults for the checker and drawing blocks.
// Coordinates are 8-bit column / 7-bit row and colours are 3 bits wide.
package fb_pkg;
  localparam int SCR_W_DEF = 160;
  localparam int SCR_H_DEF = 120;

  typedef logic [2:0] colour_t;
  typedef logic [7:0] fb_x_t;
  typedef logic [6:0] fb_y_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } chk_state_t;

  // Metadata carried alongside an outstanding read until its data returns.
  typedef struct packed {
    logic    vld;
    logic    last;
    colour_t exp;
    fb_x_t   x;
    fb_y_t   y;
  } cmp_tag_t;
endpackage

// File: rtl/fb_raster_cnt.sv
// Raster-order x/y counter, x fastest. It wraps to (0,0) after the last pixel,
// so it rests at the origin whenever it is not being stepped.
module fb_raster_cnt
  import fb_pkg::*;
#(
  parameter int SCR_W = SCR_W_DEF,
  parameter int SCR_H = SCR_H_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_step,
  output logic [7:0] o_x,
  output logic [6:0] o_y,
  output logic       o_last
);
  fb_x_t r_x;
  fb_y_t r_y;
  logic  w_x_end;
  logic  w_y_end;

  assign w_x_end = (r_x == fb_x_t'(SCR_W - 1));
  assign w_y_end = (r_y == fb_y_t'(SCR_H - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_step) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= w_y_end ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = w_x_end && w_y_end;
endmodule

// File: rtl/fb_checker.sv
// Full-frame framebuffer checker: reads every pixel in raster order, compares it
// with a stripe or solid-colour expectation and reports counts and first error.
module fb_checker
  import fb_pkg::*;
#(
  parameter int SCR_W  = SCR_W_DEF,
  parameter int SCR_H  = SCR_H_DEF,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [2:0]  exp_colour,
  output logic        rd_en,
  output logic [7:0]  rd_x,
  output logic [6:0]  rd_y,
  input  logic [2:0]  rd_colour,
  output logic        done,
  output logic [14:0] correct_cnt,
  output logic [14:0] wrong_cnt,
  output logic        err_flag,
  output logic [7:0]  first_err_x,
  output logic [6:0]  first_err_y
);
  chk_state_t  r_state;
  logic        r_rd_en;
  logic        r_done;
  logic        r_mode;
  colour_t     r_exp_colour;
  logic [14:0] r_correct;
  logic [14:0] r_wrong;
  logic        r_err;
  fb_x_t       r_ferr_x;
  fb_y_t       r_ferr_y;

  fb_x_t       w_x;
  fb_y_t       w_y;
  logic        w_last;
  logic        w_step;
  logic        w_clr;
  logic        w_match;
  cmp_tag_t    w_tag_in;
  cmp_tag_t    w_tag_out;
  cmp_tag_t    w_stage [RD_LAT+1];

  assign w_step = (r_state == ST_SCAN);
  assign w_clr  = (r_state == ST_IDLE) && start;

  fb_raster_cnt #(
    .SCR_W (SCR_W),
    .SCR_H (SCR_H)
  ) u_raster (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_step (w_step),
    .o_x    (w_x),
    .o_y    (w_y),
    .o_last (w_last)
  );

  always_comb begin
    w_tag_in      = '0;
    w_tag_in.vld  = r_rd_en;
    w_tag_in.last = r_rd_en && w_last;
    w_tag_in.exp  = r_mode ? r_exp_colour : w_x[2:0];
    w_tag_in.x    = w_x;
    w_tag_in.y    = w_y;
  end

  // Delay the expectation by the read latency so it lines up with rd_colour.
  assign w_stage[0] = w_tag_in;
  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
      cmp_tag_t r_tag;
      always_ff @(posedge clk) begin
        if (rst) r_tag <= '0;
        else     r_tag <= w_stage[gi];
      end
      assign w_stage[gi+1] = r_tag;
    end
  endgenerate
  assign w_tag_out = w_stage[RD_LAT];
  assign w_match   = (rd_colour == w_tag_out.exp);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rd_en      <= 1'b0;
      r_done       <= 1'b0;
      r_mode       <= 1'b0;
      r_exp_colour <= '0;
      r_correct    <= '0;
      r_wrong      <= '0;
      r_err        <= 1'b0;
      r_ferr_x     <= '0;
      r_ferr_y     <= '0;
    end else begin
      if (w_tag_out.vld) begin
        if (w_match) begin
          r_correct <= r_correct + 15'd1;
        end else begin
          r_wrong <= r_wrong + 15'd1;
          if (!r_err) begin
            r_err    <= 1'b1;
            r_ferr_x <= w_tag_out.x;
            r_ferr_y <= w_tag_out.y;
          end
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_correct    <= '0;
            r_wrong      <= '0;
            r_err        <= 1'b0;
            r_ferr_x     <= '0;
            r_ferr_y     <= '0;
            r_mode       <= mode;
            r_exp_colour <= exp_colour;
            r_rd_en      <= 1'b1;
            r_state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_last) begin
            r_rd_en <= 1'b0;
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_tag_out.vld && w_tag_out.last) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!start) begin
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_en       = r_rd_en;
  assign rd_x        = w_x;
  assign rd_y        = w_y;
  assign done        = r_done;
  assign correct_cnt = r_correct;
  assign wrong_cnt   = r_wrong;
  assign err_flag    = r_err;
  assign first_err_x = r_ferr_x;
  assign first_err_y = r_ferr_y;
endmodule

// File: tb/tb_fb_checker.sv
// Directed bench for fb_checker with a 1-cycle-latency framebuffer model and
// a read-address monitor.
module tb_fb_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [2:0]  exp_colour = 3'd0;
  logic        rd_en;
  logic [7:0]  rd_x;
  logic [6:0]  rd_y;
  logic [2:0]  rd_colour = 3'd0;
  logic        done;
  logic [14:0] correct_cnt;
  logic [14:0] wrong_cnt;
  logic        err_flag;
  logic [7:0]  first_err_x;
  logic [6:0]  first_err_y;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mon_x;
  logic [6:0] mon_y;
  int         rd_cnt;
  int         addr_err;
  int         cyc;

  logic [2:0] fb_mem [0:119][0:159];

  fb_checker dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .exp_colour  (exp_colour),
    .rd_en       (rd_en),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_colour   (rd_colour),
    .done        (done),
    .correct_cnt (correct_cnt),
    .wrong_cnt   (wrong_cnt),
    .err_flag    (err_flag),
    .first_err_x (first_err_x),
    .first_err_y (first_err_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) rd_colour <= fb_mem[rd_y][rd_x];
  end

  // Address monitor: expects strict raster order while rd_en, origin otherwise.
  always @(negedge clk) begin
    if (rd_en) begin
      if (rd_x !== mon_x || rd_y !== mon_y) addr_err++;
      rd_cnt++;
      if (mon_x == 8'd159) begin
        mon_x = '0;
        mon_y = mon_y + 7'd1;
      end else begin
        mon_x = mon_x + 8'd1;
      end
    end else if (rd_x !== '0 || rd_y !== '0) begin
      addr_err++;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic fill_stripe();
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        fb_mem[y[6:0]][x[7:0]] = x[2:0];
  endtask

  task automatic fill_const(input logic [2:0] c);
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        fb_mem[y[6:0]][x[7:0]] = c;
  endtask

  // Starts a run from a negedge and waits (bounded) for done.
  task automatic run_frame(input logic m, input logic [2:0] ec, input bit drop);
    mon_x = '0;
    mon_y = '0;
    rd_cnt = 0;
    addr_err = 0;
    mode = m;
    exp_colour = ec;
    start = 1'b1;
    cyc = 0;
    while (cyc < 25000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) begin
        chk("start_clears", int'(correct_cnt) + int'(wrong_cnt) + int'(err_flag), 0);
        chk("rd_en_in_scan", int'(rd_en), 1);
      end
      if (cyc == 10) begin
        mode = ~m;
        exp_colour = ~ec;
      end
      if (drop && cyc == 100) start = 1'b0;
      if (done) break;
    end
    chk("done_latency", cyc, 19202);
    chk("addr_seq_err", addr_err, 0);
    chk("read_count", rd_cnt, 19200);
  endtask

  initial begin
    mon_x = '0;
    mon_y = '0;
    rd_cnt = 0;
    addr_err = 0;
    fill_stripe();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_x", int'(rd_x), 0);
    chk("rst_rd_y", int'(rd_y), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_correct", int'(correct_cnt), 0);
    chk("rst_wrong", int'(wrong_cnt), 0);
    chk("rst_err", int'(err_flag), 0);
    chk("rst_ferr_x", int'(first_err_x), 0);
    chk("rst_ferr_y", int'(first_err_y), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_cmp", int'(correct_cnt) + int'(wrong_cnt), 0);

    // Clean stripe frame.
    run_frame(1'b0, 3'd0, 1'b0);
    chk("a_correct", int'(correct_cnt), 19200);
    chk("a_wrong", int'(wrong_cnt), 0);
    chk("a_err", int'(err_flag), 0);

    // Start held in DONE, then dropped.
    repeat (3) @(negedge clk);
    chk("hold_done", int'(done), 1);
    chk("hold_correct", int'(correct_cnt), 19200);
    start = 1'b0;
    @(negedge clk);
    chk("drop_done", int'(done), 0);
    chk("drop_correct_held", int'(correct_cnt), 19200);
    repeat (2) @(negedge clk);
    chk("idle_correct_held", int'(correct_cnt), 19200);

    // Two bad pixels; start dropped mid-scan.
    fb_mem[7'd52][8'd37] = 3'd0;
    fb_mem[7'd90][8'd100] = 3'd0;
    run_frame(1'b0, 3'd0, 1'b1);
    chk("b_wrong", int'(wrong_cnt), 2);
    chk("b_correct", int'(correct_cnt), 19198);
    chk("b_err", int'(err_flag), 1);
    chk("b_ferr_x", int'(first_err_x), 37);
    chk("b_ferr_y", int'(first_err_y), 52);
    @(negedge clk);
    chk("b_done_pulse_end", int'(done), 0);
    chk("b_wrong_held", int'(wrong_cnt), 2);
    repeat (2) @(negedge clk);

    // Solid colour, matching expectation.
    fill_const(3'd5);
    run_frame(1'b1, 3'd5, 1'b0);
    chk("c1_correct", int'(correct_cnt), 19200);
    chk("c1_wrong", int'(wrong_cnt), 0);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset at cycle 5000 of SCAN.
    mode = 1'b1;
    exp_colour = 3'd5;
    start = 1'b1;
    @(posedge clk);
    repeat (5000) @(posedge clk);
    @(negedge clk);
    chk("d_scanning", int'(rd_en), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("d_rd_en", int'(rd_en), 0);
    chk("d_rd_x", int'(rd_x), 0);
    chk("d_rd_y", int'(rd_y), 0);
    chk("d_counts", int'(correct_cnt) + int'(wrong_cnt), 0);
    chk("d_done", int'(done), 0);
    @(negedge clk);
    chk("d_no_cmp_after_rst", int'(correct_cnt) + int'(wrong_cnt), 0);

    // Solid colour, mismatching expectation, after the aborted run.
    run_frame(1'b1, 3'd2, 1'b0);
    chk("c2_wrong", int'(wrong_cnt), 19200);
    chk("c2_correct", int'(correct_cnt), 0);
    chk("c2_err", int'(err_flag), 1);
    chk("c2_ferr_x", int'(first_err_x), 0);
    chk("c2_ferr_y", int'(first_err_y), 0);
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
